// File: rtl/debug_scan_pkg.sv
// debug_scan_pkg: shared scan states and virtual-JTAG IR codes for the debug scan master.
package debug_scan_pkg;

    typedef enum logic [2:0] {IDLE, UIR, CDR, SDR, UDR, DONE} scan_state_t;

    localparam logic [1:0] IR_OCIMEM    = 2'b00;
    localparam logic [1:0] IR_TRACEMEM  = 2'b01;
    localparam logic [1:0] IR_BREAK     = 2'b10;
    localparam logic [1:0] IR_TRACECTRL = 2'b11;

    localparam int DR_WIDTH_DEFAULT = 38;

endpackage

// File: rtl/debug_scan_tck_gen.sv
// debug_scan_tck_gen: TCK divider with one-clk rise/fall event strobes.
// TCK is held low and the divider cleared whenever en is low.
module debug_scan_tck_gen #(
    parameter int TCK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic vji_tck,
    output logic tck_rise,
    output logic tck_fall
);
    logic [7:0] cnt;
    logic       tc;

    assign tc       = en && cnt == 8'(TCK_DIV - 1);
    assign tck_rise = tc && !vji_tck;
    assign tck_fall = tc && vji_tck;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            vji_tck <= 1'b0;
        end else if (!en) begin
            cnt     <= '0;
            vji_tck <= 1'b0;
        end else begin
            cnt     <= tc ? '0 : cnt + 8'd1;
            vji_tck <= vji_tck ^ tc;
        end
    end

endmodule

// File: rtl/debug_jtag_scan_master.sv
// debug_jtag_scan_master: runs one UIR/CDR/SDR/UDR virtual-JTAG scan per command.
// Define DEBUG_SCAN_IR_SKIP_EN to skip UIR when the IR matches the last one sent.
module debug_jtag_scan_master
    import debug_scan_pkg::*;
#(
    parameter int DR_WIDTH = DR_WIDTH_DEFAULT,
    parameter int IR_WIDTH = 2,
    parameter int TCK_DIV  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_data,
    output logic                rsp_valid,
    output logic [DR_WIDTH-1:0] rsp_data,
    output logic [IR_WIDTH-1:0] rsp_ir_out,
    output logic                busy,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [IR_WIDTH-1:0] vji_ir_in,
    input  logic [IR_WIDTH-1:0] vji_ir_out,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic                vji_rti
);
    localparam int CW = $clog2(DR_WIDTH + 1);

    scan_state_t         state, state_d;
    logic [DR_WIDTH-1:0] sr;
    logic [CW-1:0]       bit_cnt;
    logic                tck_rise, tck_fall, accept, ir_skip;

    assign cmd_ready = state == IDLE;
    assign accept    = cmd_valid && cmd_ready;
    assign busy      = state != IDLE && state != DONE;
    assign rsp_valid = state == DONE;
    assign vji_rti   = !busy;
    assign vji_uir   = state == UIR;
    assign vji_cdr   = state == CDR;
    assign vji_sdr   = state == SDR;
    assign vji_udr   = state == UDR;

`ifdef DEBUG_SCAN_IR_SKIP_EN
    // vji_ir_in already holds the last IR sent and rsp_ir_out its sampled status
    logic ir_vld;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ir_vld <= 1'b0;
        else if (accept)
            ir_vld <= 1'b1;
    end
    assign ir_skip = ir_vld && cmd_ir == vji_ir_in;
`else
    assign ir_skip = 1'b0;
`endif

    debug_scan_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck_gen (
        .clk      (clk),
        .reset    (reset),
        .en       (busy),
        .vji_tck  (vji_tck),
        .tck_rise (tck_rise),
        .tck_fall (tck_fall)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = accept ? (ir_skip ? CDR : UIR) : IDLE;
            UIR:     state_d = tck_fall ? CDR : UIR;
            CDR:     state_d = tck_fall ? SDR : CDR;
            SDR:     state_d = (tck_fall && bit_cnt == CW'(DR_WIDTH)) ? UDR : SDR;
            UDR:     state_d = tck_fall ? DONE : UDR;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr         <= '0;
            bit_cnt    <= '0;
            vji_tdi    <= 1'b0;
            vji_ir_in  <= '0;
            rsp_data   <= '0;
            rsp_ir_out <= '0;
        end else begin
            if (accept) begin
                vji_ir_in <= cmd_ir;
                sr        <= cmd_data;
                bit_cnt   <= '0;
            end
            if (vji_uir && tck_rise)
                rsp_ir_out <= vji_ir_out;
            if (vji_sdr && tck_rise) begin
                sr      <= {vji_tdo, sr[DR_WIDTH-1:1]};
                bit_cnt <= bit_cnt + CW'(1);
            end
            // sr[0] already holds the next bit because the shift happened on the rise
            if ((vji_cdr || vji_sdr) && tck_fall)
                vji_tdi <= sr[0];
            if (vji_udr && tck_fall)
                rsp_data <= sr;
        end
    end

endmodule

// File: tb/tb_debug_jtag_scan_master.sv
// tb_debug_jtag_scan_master: directed scans against a TDO responder model.
module tb_debug_jtag_scan_master;
    import debug_scan_pkg::*;
    localparam int W = 38;
`ifdef DEBUG_SCAN_IR_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    int tests = 0, failed = 0;

    logic         cmd_valid = 1'b0, cmd_ready, rsp_valid, busy;
    logic [1:0]   cmd_ir = '0, rsp_ir_out, ir_in, ir_out = '0;
    logic [W-1:0] cmd_data = '0, rsp_data;
    logic         tck, tdi, tdo, uir, cdr, sdr, udr, rti;

    debug_jtag_scan_master dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ir(cmd_ir), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_ir_out(rsp_ir_out), .busy(busy), .vji_tck(tck), .vji_tdi(tdi), .vji_tdo(tdo),
        .vji_ir_in(ir_in), .vji_ir_out(ir_out), .vji_uir(uir), .vji_cdr(cdr),
        .vji_sdr(sdr), .vji_udr(udr), .vji_rti(rti)
    );

    logic         cmd_valid1 = 1'b0, cmd_ready1, rsp_valid1, busy1;
    logic [1:0]   rsp_ir_out1, ir_in1;
    logic [W-1:0] cmd_data1 = '0, rsp_data1;
    logic         tck1, tdi1, tdo1, uir1, cdr1, sdr1, udr1, rti1;

    debug_jtag_scan_master #(.TCK_DIV(1)) dut1 (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
        .cmd_ir(2'b00), .cmd_data(cmd_data1), .rsp_valid(rsp_valid1), .rsp_data(rsp_data1),
        .rsp_ir_out(rsp_ir_out1), .busy(busy1), .vji_tck(tck1), .vji_tdi(tdi1), .vji_tdo(tdo1),
        .vji_ir_in(ir_in1), .vji_ir_out(2'b00), .vji_uir(uir1), .vji_cdr(cdr1),
        .vji_sdr(sdr1), .vji_udr(udr1), .vji_rti(rti1)
    );

    // Responders: present pat[k] during SDR period k, record TDI at each TCK rise
    logic [W-1:0] pat = '0, tdi_cap = '0, pat1 = '0, tdi_cap1 = '0;
    int ridx = 0, nbits = 0, ridx1 = 0, nbits1 = 0;
    assign tdo  = (ridx < W) ? pat[ridx[5:0]] : 1'b0;
    assign tdo1 = (ridx1 < W) ? pat1[ridx1[5:0]] : 1'b0;

    always @(posedge tck or posedge rti)
        if (rti) begin nbits = ridx; ridx = 0; end
        else if (sdr && ridx < W) begin tdi_cap[ridx[5:0]] = tdi; ridx++; end

    always @(posedge tck1 or posedge rti1)
        if (rti1) begin nbits1 = ridx1; ridx1 = 0; end
        else if (sdr1 && ridx1 < W) begin tdi_cap1[ridx1[5:0]] = tdi1; ridx1++; end

    int lat, wait_n, n_uir, n_cdr, n_sdr, n_udr, hot_bad, rti_bad, irin_bad, rdy_bad, tck_bad;
    int lat1, tck_bad1;

    // lat = clk edges from the accept edge to the edge that raises rsp_valid
    task automatic scan(input logic [1:0] ir, input logic [W-1:0] data, input logic [W-1:0] p,
                        input logic [1:0] iro, input logic keep);
        int j;
        cmd_ir = ir; cmd_data = data; pat = p; ir_out = iro; cmd_valid = 1'b1;
        wait_n = 0;
        while (!cmd_ready && wait_n < 20) begin @(negedge clk); wait_n++; end
        n_uir = 0; n_cdr = 0; n_sdr = 0; n_udr = 0;
        hot_bad = 0; rti_bad = 0; irin_bad = 0; rdy_bad = 0; tck_bad = 0;
        j = 0;
        do begin
            @(negedge clk);
            j++;
            cmd_valid = keep;
            if (!rsp_valid) begin
                n_uir += int'(uir); n_cdr += int'(cdr); n_sdr += int'(sdr); n_udr += int'(udr);
                hot_bad  += int'($countones({uir, cdr, sdr, udr, rti}) != 1);
                rti_bad  += int'(rti);
                irin_bad += int'(uir && ir_in != ir);
                rdy_bad  += int'(cmd_ready);
                tck_bad  += int'(tck != 1'(((j - 1) / 4) % 2));
            end
        end while (!rsp_valid && j < 1000);
        lat = rsp_valid ? j - 1 : -1;
    endtask

    task automatic scan1(input logic [W-1:0] data, input logic [W-1:0] p);
        int j;
        cmd_data1 = data; pat1 = p; cmd_valid1 = 1'b1;
        j = 0;
        while (!cmd_ready1 && j < 20) begin @(negedge clk); j++; end
        tck_bad1 = 0;
        j = 0;
        do begin
            @(negedge clk);
            j++;
            cmd_valid1 = 1'b0;
            if (!rsp_valid1) tck_bad1 += int'(tck1 != 1'((j - 1) % 2));
        end while (!rsp_valid1 && j < 1000);
        lat1 = rsp_valid1 ? j - 1 : -1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        tests++;
        if ({tck, tdi, ir_in, uir, cdr, sdr, udr, rti, busy, cmd_ready, rsp_valid} !== 13'b0_0_00_0000_1_0_1_0) begin
            failed++;
            $display("FAIL reset_ctrl: got %b want %b",
                     {tck, tdi, ir_in, uir, cdr, sdr, udr, rti, busy, cmd_ready, rsp_valid}, 13'b0_0_00_0000_1_0_1_0);
        end
        tests++;
        if ({rsp_data, rsp_ir_out} !== '0) begin
            failed++; $display("FAIL reset_rsp: got %h/%b want 0/0", rsp_data, rsp_ir_out);
        end
        tests++;
        if ({cmd_ready1, busy1, rti1} !== 3'b101) begin
            failed++; $display("FAIL reset_dut1: got %b want 101", {cmd_ready1, busy1, rti1});
        end
    endtask

    task automatic test_basic;
        scan(IR_OCIMEM, 38'h2A_5555_AAAA, 38'h15_0F0F_F0F0, 2'b11, 1'b0);
        tests++;
        if (lat !== 328) begin failed++; $display("FAIL basic_lat: got %0d want 328", lat); end
        tests++;
        if (rsp_data !== 38'h15_0F0F_F0F0) begin
            failed++; $display("FAIL basic_data: got %h want %h", rsp_data, 38'h15_0F0F_F0F0);
        end
        tests++;
        if (tdi_cap !== 38'h2A_5555_AAAA || nbits !== W) begin
            failed++; $display("FAIL basic_tdi: got %h (%0d bits) want %h (38 bits)", tdi_cap, nbits, 38'h2A_5555_AAAA);
        end
        tests++;
        if (rsp_ir_out !== 2'b11) begin failed++; $display("FAIL basic_ir_out: got %b want 11", rsp_ir_out); end
        tests++;
        if (tck_bad !== 0) begin failed++; $display("FAIL basic_tck: %0d wrong TCK cycles, want 0", tck_bad); end
    endtask

    task automatic test_strobes;
        scan(IR_TRACECTRL, 38'h3F_0000_0001, 38'h00_FFFF_0000, 2'b01, 1'b0);
        tests++;
        if ({n_uir, n_cdr, n_sdr, n_udr} !== {32'd8, 32'd8, 32'd304, 32'd8}) begin
            failed++; $display("FAIL strobe_len: got uir %0d cdr %0d sdr %0d udr %0d want 8/8/304/8", n_uir, n_cdr, n_sdr, n_udr);
        end
        tests++;
        if (hot_bad !== 0 || rti_bad !== 0) begin
            failed++; $display("FAIL strobe_onehot: got %0d non-onehot, %0d rti cycles want 0/0", hot_bad, rti_bad);
        end
        tests++;
        if (irin_bad !== 0) begin failed++; $display("FAIL strobe_ir_in: got %0d bad cycles want 0", irin_bad); end
        tests++;
        if ({uir, cdr, sdr, udr, rti, busy, cmd_ready} !== 7'b0000_1_0_0) begin
            failed++; $display("FAIL strobe_done: got %b want 0000100", {uir, cdr, sdr, udr, rti, busy, cmd_ready});
        end
        tests++;
        if (rsp_data !== 38'h00_FFFF_0000) begin
            failed++; $display("FAIL strobe_data: got %h want %h", rsp_data, 38'h00_FFFF_0000);
        end
    endtask

    task automatic test_back_to_back;
        scan(IR_TRACEMEM, 38'h01_2345_6789, 38'h3E_DCBA_9876, 2'b10, 1'b1);
        tests++;
        if (rdy_bad !== 0) begin failed++; $display("FAIL b2b_ready_busy: got %0d ready cycles want 0", rdy_bad); end
        tests++;
        if (lat !== 328 || rsp_data !== 38'h3E_DCBA_9876 || rsp_ir_out !== 2'b10) begin
            failed++; $display("FAIL b2b_first: got %0d/%h/%b want 328/%h/10", lat, rsp_data, rsp_ir_out, 38'h3E_DCBA_9876);
        end
        tests++;
        if (cmd_ready !== 1'b0) begin failed++; $display("FAIL b2b_ready_done: got %b want 0", cmd_ready); end
        scan(IR_BREAK, 38'h2B_0F1E_2D3C, 38'h0C_3C3C_A5A5, 2'b01, 1'b0);
        tests++;
        if (wait_n !== 1) begin failed++; $display("FAIL b2b_accept_gap: got %0d want 1", wait_n); end
        tests++;
        if (lat !== 328 || rsp_data !== 38'h0C_3C3C_A5A5 || tdi_cap !== 38'h2B_0F1E_2D3C) begin
            failed++; $display("FAIL b2b_second: got %0d/%h/%h want 328/%h/%h", lat, rsp_data, tdi_cap,
                               38'h0C_3C3C_A5A5, 38'h2B_0F1E_2D3C);
        end
        tests++;
        if (rsp_ir_out !== 2'b01) begin failed++; $display("FAIL b2b_ir_out: got %b want 01", rsp_ir_out); end
    endtask

    task automatic test_reset_mid_scan;
        int n, nv;
        cmd_ir = IR_TRACECTRL; cmd_data = 38'h3F_FFFF_FFFF; pat = 38'h15_5555_5555; ir_out = 2'b11;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (ridx < 17 && n < 2000) begin @(negedge clk); n++; end
        tests++;
        if (ridx !== 17) begin failed++; $display("FAIL mid_rise_count: got %0d want 17", ridx); end
        reset = 1'b1;
        #1;
        tests++;
        if ({tck, tdi, ir_in, uir, cdr, sdr, udr, rti, busy, rsp_valid} !== 12'b0_0_00_0000_1_0_0) begin
            failed++; $display("FAIL mid_reset_ctrl: got %b want %b",
                               {tck, tdi, ir_in, uir, cdr, sdr, udr, rti, busy, rsp_valid}, 12'b0_0_00_0000_1_0_0);
        end
        tests++;
        if ({rsp_data, rsp_ir_out} !== '0) begin
            failed++; $display("FAIL mid_reset_rsp: got %h/%b want 0/0", rsp_data, rsp_ir_out);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        nv = 0;
        repeat (400) begin @(negedge clk); nv += int'(rsp_valid); end
        tests++;
        if (nv !== 0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            failed++; $display("FAIL mid_no_rsp: got %0d pulses busy %b ready %b want 0/0/1", nv, busy, cmd_ready);
        end
        scan(IR_OCIMEM, 38'h12_3456_789A, 38'h2D_CBA9_8765, 2'b10, 1'b0);
        tests++;
        if (lat !== 328 || rsp_data !== 38'h2D_CBA9_8765 || tdi_cap !== 38'h12_3456_789A || nbits !== W) begin
            failed++; $display("FAIL mid_rescan: got %0d/%h/%h/%0d want 328/%h/%h/38", lat, rsp_data, tdi_cap, nbits,
                               38'h2D_CBA9_8765, 38'h12_3456_789A);
        end
    endtask

    task automatic test_tck_div1;
        scan1(38'h33_CCCC_3333, 38'h0A_F00F_5AA5);
        tests++;
        if (lat1 !== 82) begin failed++; $display("FAIL div1_lat: got %0d want 82", lat1); end
        tests++;
        if (tck_bad1 !== 0) begin failed++; $display("FAIL div1_tck: %0d wrong TCK cycles, want 0", tck_bad1); end
        tests++;
        if (rsp_data1 !== 38'h0A_F00F_5AA5 || tdi_cap1 !== 38'h33_CCCC_3333 || nbits1 !== W) begin
            failed++; $display("FAIL div1_data: got %h/%h/%0d want %h/%h/38", rsp_data1, tdi_cap1, nbits1,
                               38'h0A_F00F_5AA5, 38'h33_CCCC_3333);
        end
    endtask

    task automatic test_ir_skip;
        scan(IR_BREAK, 38'h05_1111_2222, 38'h3A_3333_4444, 2'b01, 1'b0);
        tests++;
        if (lat !== 328 || n_uir !== 8 || rsp_ir_out !== 2'b01 || rsp_data !== 38'h3A_3333_4444) begin
            failed++; $display("FAIL skip_first: got %0d/%0d/%b/%h want 328/8/01/%h", lat, n_uir, rsp_ir_out, rsp_data,
                               38'h3A_3333_4444);
        end
        scan(IR_BREAK, 38'h16_5555_6666, 38'h27_7777_8888, 2'b11, 1'b0);
        tests++;
        if (lat !== (SKIP ? 320 : 328) || n_uir !== (SKIP ? 0 : 8)) begin
            failed++; $display("FAIL skip_second_timing: got %0d/%0d want %0d/%0d", lat, n_uir,
                               SKIP ? 320 : 328, SKIP ? 0 : 8);
        end
        tests++;
        if (rsp_ir_out !== (SKIP ? 2'b01 : 2'b11) || rsp_data !== 38'h27_7777_8888) begin
            failed++; $display("FAIL skip_second_rsp: got %b/%h want %b/%h", rsp_ir_out, rsp_data,
                               SKIP ? 2'b01 : 2'b11, 38'h27_7777_8888);
        end
        scan(IR_TRACEMEM, 38'h09_9999_AAAA, 38'h34_BBBB_CCCC, 2'b10, 1'b0);
        tests++;
        if (lat !== 328 || n_uir !== 8 || irin_bad !== 0) begin
            failed++; $display("FAIL skip_third_timing: got %0d/%0d/%0d want 328/8/0", lat, n_uir, irin_bad);
        end
        tests++;
        if (rsp_ir_out !== 2'b10 || rsp_data !== 38'h34_BBBB_CCCC) begin
            failed++; $display("FAIL skip_third_rsp: got %b/%h want 10/%h", rsp_ir_out, rsp_data, 38'h34_BBBB_CCCC);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_strobes;
        test_back_to_back;
        test_reset_mid_scan;
        test_tck_div1;
        test_ir_skip;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
